// File: rtl/zaxxon_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// zaxxon_rom_arbiter_if : bus bundle between the ROM arbiter, its clients
//                         (download, video, CPU) and the shared ROM RAM.
// Rev 1.0
// ============================================================================
interface zaxxon_rom_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              dl_download;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              game_reset;
  logic              dl_overflow;
  logic [15:0]       dl_checksum;

  modport slave (
    input  dl_download, dl_wr, dl_addr, dl_data,
    input  vid_req, vid_addr, cpu_req, cpu_addr, mem_dout,
    output vid_ack, vid_data, cpu_ack, cpu_data,
    output mem_addr, mem_we, mem_din,
    output game_reset, dl_overflow, dl_checksum
  );

  modport master (
    output dl_download, dl_wr, dl_addr, dl_data,
    output vid_req, vid_addr, cpu_req, cpu_addr, mem_dout,
    input  vid_ack, vid_data, cpu_ack, cpu_data,
    input  mem_addr, mem_we, mem_din,
    input  game_reset, dl_overflow, dl_checksum
  );
endinterface
`default_nettype wire

// File: rtl/zaxxon_rom_arbiter.sv
`default_nettype none
// ============================================================================
// zaxxon_rom_arbiter : shares one synchronous ROM RAM between the HPS
//                      download writer, video fetch and CPU fetch; sequences
//                      the core reset. Optional macro: ROM_CHECKSUM_EN.
// Rev 1.0
// ============================================================================
module zaxxon_rom_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int CPU_STARVE  = 4,
  parameter int HOLD_CYCLES = 16
) (
  input wire logic            clock_24,
  input wire logic            reset_n,
  zaxxon_rom_arbiter_if.slave bus
);
  localparam int SW = $clog2(CPU_STARVE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAP  = 2'd2
  } state_t;

  state_t            state_q;
  logic              win_cpu_q;
  logic [SW-1:0]     starve_q;
  logic              buf_full_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [7:0]        buf_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [7:0]        mem_din_q;
  logic              vid_ack_q, cpu_ack_q;
  logic [7:0]        vid_data_q, cpu_data_q;
  logic              game_reset_q;
  logic [7:0]        hold_q;
  logic              overflow_q;

  logic dl_wr_v, arb_edge, grant_ok, grant_vid, grant_cpu;

  always_comb begin
    dl_wr_v   = bus.dl_wr & bus.dl_download;
    arb_edge  = (state_q == S_IDLE) | (state_q == S_CAP);
    grant_ok  = arb_edge & ~bus.dl_download & ~buf_full_q;
    grant_cpu = grant_ok & bus.cpu_req &
                (~bus.vid_req | (starve_q == SW'(CPU_STARVE)));
    grant_vid = grant_ok & bus.vid_req & ~grant_cpu;
  end

  always_ff @(posedge clock_24) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      win_cpu_q  <= 1'b0;
      starve_q   <= '0;
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      if (state_q == S_WAIT) begin
        state_q <= S_CAP;
        if (dl_wr_v) begin
          if (buf_full_q) begin
            overflow_q <= 1'b1;
          end else begin
            buf_full_q <= 1'b1;
            buf_addr_q <= bus.dl_addr;
            buf_data_q <= bus.dl_data;
          end
        end
      end else begin
        if (state_q == S_CAP) begin
          if (win_cpu_q) begin
            cpu_data_q <= bus.mem_dout;
            cpu_ack_q  <= 1'b1;
          end else begin
            vid_data_q <= bus.mem_dout;
            vid_ack_q  <= 1'b1;
          end
        end
        // A buffered byte drains first; a byte arriving on that same edge is lost.
        if (buf_full_q) begin
          mem_addr_q <= buf_addr_q;
          mem_din_q  <= buf_data_q;
          mem_we_q   <= 1'b1;
          buf_full_q <= 1'b0;
          state_q    <= S_IDLE;
          if (dl_wr_v) overflow_q <= 1'b1;
        end else if (dl_wr_v) begin
          mem_addr_q <= bus.dl_addr;
          mem_din_q  <= bus.dl_data;
          mem_we_q   <= 1'b1;
          state_q    <= S_IDLE;
        end else if (grant_vid | grant_cpu) begin
          mem_addr_q <= grant_cpu ? bus.cpu_addr : bus.vid_addr;
          win_cpu_q  <= grant_cpu;
          state_q    <= S_WAIT;
        end else begin
          state_q <= S_IDLE;
        end
      end
      if (!bus.cpu_req || grant_cpu) begin
        starve_q <= '0;
      end else if (grant_vid && (starve_q != SW'(CPU_STARVE))) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Core reset is held through the download and for HOLD_CYCLES afterwards.
  always_ff @(posedge clock_24) begin
    if (!reset_n) begin
      game_reset_q <= 1'b1;
      hold_q       <= 8'(HOLD_CYCLES);
    end else if (bus.dl_download) begin
      game_reset_q <= 1'b1;
      hold_q       <= 8'(HOLD_CYCLES);
    end else if (hold_q != 8'd0) begin
      hold_q <= hold_q - 8'd1;
      if (hold_q == 8'd1) game_reset_q <= 1'b0;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic        dl_prev_q;
  logic [15:0] checksum_q;

  always_ff @(posedge clock_24) begin
    if (!reset_n) begin
      dl_prev_q  <= 1'b0;
      checksum_q <= '0;
    end else begin
      dl_prev_q <= bus.dl_download;
      if (bus.dl_download && !dl_prev_q) begin
        checksum_q <= '0;
      end else if (mem_we_q) begin
        checksum_q <= checksum_q + {8'd0, mem_din_q};
      end
    end
  end

  assign bus.dl_checksum = checksum_q;
`else
  assign bus.dl_checksum = 16'd0;
`endif

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.vid_ack     = vid_ack_q;
  assign bus.vid_data    = vid_data_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_data    = cpu_data_q;
  assign bus.game_reset  = game_reset_q;
  assign bus.dl_overflow = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_zaxxon_rom_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for zaxxon_rom_arbiter: RAM model plus scenario tasks
// checked against arithmetic expectations and a randomized read scoreboard.
module tb_zaxxon_rom_arbiter;
  localparam int ADDR_W      = 17;
  localparam int CPU_STARVE  = 4;
  localparam int HOLD_CYCLES = 16;
  localparam int DEPTH       = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] seed;

  bit [7:0] wr_data  [0:DEPTH-1];
  bit       wr_valid [0:DEPTH-1];

  zaxxon_rom_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  zaxxon_rom_arbiter #(
    .ADDR_W(ADDR_W), .CPU_STARVE(CPU_STARVE), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clock_24(clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    if (a == 17'h01234) return 8'hA5;
    h = ({15'd0, a} * 32'h9E3779B1) ^ seed;
    return h[20:13];
  endfunction

  function automatic logic [7:0] mem_peek(input logic [ADDR_W-1:0] a);
    if (wr_valid[a]) return wr_data[a];
    return rom_byte(a);
  endfunction

  // Single-port synchronous RAM, preloaded with rom_byte() contents.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      wr_data[bus.mem_addr]  <= bus.mem_din;
      wr_valid[bus.mem_addr] <= 1'b1;
    end
    bus.mem_dout <= mem_peek(bus.mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dl_wr   = 1'b0;
    repeat (4) tick();
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'($urandom_range(32'h100, DEPTH - 1));
  endfunction

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (bus.game_reset !== 1'b1) begin failures++; $display("FAIL reset_game_reset: got %b want 1", bus.game_reset); end
    if (bus.vid_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_acks: got %b%b want 00", bus.vid_ack, bus.cpu_ack); end
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    if (bus.dl_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", bus.dl_overflow); end
    if (bus.dl_checksum !== 16'h0) begin failures++; $display("FAIL reset_checksum: got %h want 0000", bus.dl_checksum); end
    reset_n = 1'b1;
    n = 0;
    while (bus.game_reset === 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != HOLD_CYCLES) begin failures++; $display("FAIL reset_hold_len: got %0d want %0d", n, HOLD_CYCLES); end
  endtask

  task automatic test_single_read();
    bus.vid_addr = 17'h01234;
    bus.vid_req  = 1'b1;
    tick();                       // E0: grant
    checks++;
    if (bus.vid_ack !== 1'b0) begin failures++; $display("FAIL single_early_e0: got %b want 0", bus.vid_ack); end
    tick();                       // E1
    bus.vid_req = 1'b0;
    checks++;
    if (bus.vid_ack !== 1'b0) begin failures++; $display("FAIL single_early_e1: got %b want 0", bus.vid_ack); end
    tick();                       // E2: ack
    checks += 3;
    if (bus.vid_ack !== 1'b1) begin failures++; $display("FAIL single_ack: got %b want 1", bus.vid_ack); end
    if (bus.vid_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", bus.vid_data); end
    if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL single_cpu_ack: got %b want 0", bus.cpu_ack); end
    tick();
    checks += 2;
    if (bus.vid_ack !== 1'b0) begin failures++; $display("FAIL single_ack_pulse: got %b want 0", bus.vid_ack); end
    if (bus.vid_data !== 8'hA5) begin failures++; $display("FAIL single_data_hold: got %h want a5", bus.vid_data); end
    drain();
  endtask

  task automatic test_starvation();
    logic [ADDR_W-1:0] va, ca;
    logic exp_v, exp_c;
    int k;
    va = rand_addr();
    ca = rand_addr();
    bus.vid_addr = va;
    bus.cpu_addr = ca;
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    tick();                       // E0
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_v = 1'b0;
      exp_c = 1'b0;
      if (c % 2 == 0) begin
        k = c / 2 - 1;
        if (k % (CPU_STARVE + 1) == CPU_STARVE) exp_c = 1'b1; else exp_v = 1'b1;
      end
      checks++;
      if (bus.vid_ack !== exp_v || bus.cpu_ack !== exp_c) begin
        failures++;
        $display("FAIL starve_order c=%0d: got v=%b c=%b want v=%b c=%b", c, bus.vid_ack, bus.cpu_ack, exp_v, exp_c);
      end
      if (exp_v) begin
        checks++;
        if (bus.vid_data !== rom_byte(va)) begin failures++; $display("FAIL starve_vdata c=%0d: got %h want %h", c, bus.vid_data, rom_byte(va)); end
      end
      if (exp_c) begin
        checks++;
        if (bus.cpu_data !== rom_byte(ca)) begin failures++; $display("FAIL starve_cdata c=%0d: got %h want %h", c, bus.cpu_data, rom_byte(ca)); end
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int mode, len, nv, nc, n, ev, ec;
      logic [ADDR_W-1:0] va, ca;
      mode = int'($urandom_range(0, 2));
      len  = int'($urandom_range(2, 12));
      va = rand_addr();
      ca = rand_addr();
      bus.vid_addr = va;
      bus.cpu_addr = ca;
      bus.vid_req  = (mode != 1);
      bus.cpu_req  = (mode != 0);
      nv = 0;
      nc = 0;
      for (int c = 0; c < len + 4; c++) begin
        if (c == len) begin bus.vid_req = 1'b0; bus.cpu_req = 1'b0; end
        tick();
        if (bus.vid_ack === 1'b1 && bus.cpu_ack === 1'b1) begin
          checks++; failures++;
          $display("FAIL rand_dual_ack r=%0d c=%0d: got both acks want at most one", r, c);
        end
        if (bus.vid_ack === 1'b1) begin
          nv++; checks++;
          if (bus.vid_data !== rom_byte(va)) begin failures++; $display("FAIL rand_vdata r=%0d: got %h want %h", r, bus.vid_data, rom_byte(va)); end
        end
        if (bus.cpu_ack === 1'b1) begin
          nc++; checks++;
          if (bus.cpu_data !== rom_byte(ca)) begin failures++; $display("FAIL rand_cdata r=%0d: got %h want %h", r, bus.cpu_data, rom_byte(ca)); end
        end
      end
      n = (len + 1) / 2;
      if (mode == 0) begin ev = n; ec = 0; end
      else if (mode == 1) begin ev = 0; ec = n; end
      else begin ec = n / (CPU_STARVE + 1); ev = n - ec; end
      checks++;
      if (nv != ev || nc != ec) begin
        failures++;
        $display("FAIL rand_counts r=%0d mode=%0d len=%0d: got v=%0d c=%0d want v=%0d c=%0d", r, mode, len, nv, nc, ev, ec);
      end
      drain();
    end
  endtask

  task automatic test_download();
    logic [7:0] bytes [3];
    logic [15:0] exp_sum;
    int n, first_ack;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bus.vid_addr = rand_addr();
    bus.cpu_addr = rand_addr();
    bus.dl_download = 1'b1;
    bus.vid_req = 1'b1;
    bus.cpu_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.dl_addr = ADDR_W'(i);
      bus.dl_data = bytes[i];
      bus.dl_wr   = 1'b1;
      tick();
      bus.dl_wr = 1'b0;
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(i) || bus.mem_din !== bytes[i]) begin
        failures++;
        $display("FAIL dl_write%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", i, bus.mem_we, bus.mem_addr, bus.mem_din, i, bytes[i]);
      end
      for (int j = 0; j < 3; j++) begin
        tick();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.vid_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin
          failures++;
          $display("FAIL dl_quiet%0d_%0d: got we=%b v=%b c=%b want 000", i, j, bus.mem_we, bus.vid_ack, bus.cpu_ack);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_peek(ADDR_W'(i)) !== bytes[i]) begin failures++; $display("FAIL dl_ram%0d: got %h want %h", i, mem_peek(ADDR_W'(i)), bytes[i]); end
    end
`ifdef ROM_CHECKSUM_EN
    exp_sum = 16'h0066;
`else
    exp_sum = 16'h0000;
`endif
    checks += 2;
    if (bus.dl_checksum !== exp_sum) begin failures++; $display("FAIL dl_checksum: got %h want %h", bus.dl_checksum, exp_sum); end
    if (bus.game_reset !== 1'b1) begin failures++; $display("FAIL dl_game_reset: got %b want 1", bus.game_reset); end
    bus.dl_download = 1'b0;
    n = 0;
    first_ack = -1;
    while (bus.game_reset === 1'b1 && n < 100) begin
      tick(); n++;
      if (first_ack < 0 && (bus.vid_ack === 1'b1 || bus.cpu_ack === 1'b1)) begin
        first_ack = n;
        checks++;
        if (bus.vid_ack !== 1'b1) begin failures++; $display("FAIL dl_first_winner: got v=%b c=%b want v=1", bus.vid_ack, bus.cpu_ack); end
      end
    end
    checks += 2;
    if (first_ack != 3) begin failures++; $display("FAIL dl_first_ack_time: got %0d want 3", first_ack); end
    if (n != HOLD_CYCLES) begin failures++; $display("FAIL dl_hold_len: got %0d want %0d", n, HOLD_CYCLES); end
    drain();
  endtask

  task automatic test_collision();
    logic [ADDR_W-1:0] va, xa, ya;
    logic [7:0] d1, d2;
    logic [15:0] exp_sum;
    va = rand_addr();
    xa = ADDR_W'($urandom_range(16, 31));
    ya = ADDR_W'($urandom_range(64, 79));
    d1 = 8'($urandom);
    d2 = ~rom_byte(ya);
    bus.vid_addr = va;
    bus.vid_req  = 1'b1;
    tick();                       // E0: read granted
    bus.vid_req     = 1'b0;
    bus.dl_download = 1'b1;
    bus.dl_addr = xa; bus.dl_data = d1; bus.dl_wr = 1'b1;
    tick();                       // E1: byte buffered
    bus.dl_addr = ya; bus.dl_data = d2; bus.dl_wr = 1'b1;
    tick();                       // E2: ack, buffer drains, second byte dropped
    bus.dl_wr = 1'b0;
    checks += 4;
    if (bus.vid_ack !== 1'b1) begin failures++; $display("FAIL coll_ack: got %b want 1", bus.vid_ack); end
    if (bus.vid_data !== rom_byte(va)) begin failures++; $display("FAIL coll_vdata: got %h want %h", bus.vid_data, rom_byte(va)); end
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== xa || bus.mem_din !== d1) begin
      failures++;
      $display("FAIL coll_buf_write: got we=%b a=%h d=%h want we=1 a=%h d=%h", bus.mem_we, bus.mem_addr, bus.mem_din, xa, d1);
    end
    if (bus.dl_overflow !== 1'b1) begin failures++; $display("FAIL coll_overflow: got %b want 1", bus.dl_overflow); end
    tick();
    tick();
    checks += 4;
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL coll_we_pulse: got %b want 0", bus.mem_we); end
    if (mem_peek(xa) !== d1) begin failures++; $display("FAIL coll_ram_x: got %h want %h", mem_peek(xa), d1); end
    if (mem_peek(ya) !== rom_byte(ya)) begin failures++; $display("FAIL coll_ram_y: got %h want %h", mem_peek(ya), rom_byte(ya)); end
`ifdef ROM_CHECKSUM_EN
    exp_sum = {8'd0, d1};
`else
    exp_sum = 16'h0000;
`endif
    if (bus.dl_checksum !== exp_sum) begin failures++; $display("FAIL coll_checksum: got %h want %h", bus.dl_checksum, exp_sum); end
    bus.dl_download = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.dl_overflow !== 1'b1) begin failures++; $display("FAIL coll_overflow_sticky: got %b want 1", bus.dl_overflow); end
    drain();
  endtask

  task automatic test_reset_mid_read();
    logic [ADDR_W-1:0] vb;
    bus.vid_addr = rand_addr();
    bus.vid_req  = 1'b1;
    tick();                       // E0: grant, FSM now waiting
    reset_n     = 1'b0;
    bus.vid_req = 1'b0;
    tick();
    checks += 4;
    if (bus.game_reset !== 1'b1) begin failures++; $display("FAIL rmid_game_reset: got %b want 1", bus.game_reset); end
    if (bus.vid_ack !== 1'b0) begin failures++; $display("FAIL rmid_ack: got %b want 0", bus.vid_ack); end
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rmid_mem_we: got %b want 0", bus.mem_we); end
    if (bus.dl_overflow !== 1'b0) begin failures++; $display("FAIL rmid_overflow: got %b want 0", bus.dl_overflow); end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.vid_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rmid_stray_ack c=%0d: got v=%b c=%b want 00", c, bus.vid_ack, bus.cpu_ack); end
    end
    vb = rand_addr();
    bus.vid_addr = vb;
    bus.vid_req  = 1'b1;
    tick();
    tick();
    bus.vid_req = 1'b0;
    tick();
    checks += 2;
    if (bus.vid_ack !== 1'b1) begin failures++; $display("FAIL rmid_new_ack: got %b want 1", bus.vid_ack); end
    if (bus.vid_data !== rom_byte(vb)) begin failures++; $display("FAIL rmid_new_data: got %h want %h", bus.vid_data, rom_byte(vb)); end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    seed            = $urandom;
    reset_n         = 1'b0;
    bus.dl_download = 1'b0;
    bus.dl_wr       = 1'b0;
    bus.dl_addr     = '0;
    bus.dl_data     = '0;
    bus.vid_req     = 1'b0;
    bus.vid_addr    = '0;
    bus.cpu_req     = 1'b0;
    bus.cpu_addr    = '0;
    test_reset();
    test_single_read();
    test_starvation();
    test_random();
    test_download();
    test_collision();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/zaxxon_rom_arbiter.md
Name: zaxxon_rom_arbiter

Overview:
Shares one single-port synchronous ROM RAM between three clients.
- The HPS ROM download writer (ioctl stream).
- The video tile/sprite fetch requester.
- The CPU program/data fetch requester.

Sits between the MiSTer top level and the zaxxon core. Also sequences the core reset so the game runs only after ROM load completes.

Parameters:
ADDR_W, 17, address width of shared ROM RAM and all address ports
CPU_STARVE, 4, consecutive video grants while CPU waits before CPU is forced to win
HOLD_CYCLES, 16, cycles game_reset stays high after download ends (1..255)

Ports:
clock_24  in  1  system clock (24 MHz)
reset_n  in  1  synchronous, active-low reset
dl_download  in  1  ROM download active (level)
dl_wr  in  1  download byte strobe, one-cycle pulse
dl_addr  in  ADDR_W  download byte address
dl_data  in  8  download byte
vid_req  in  1  video read request, held until vid_ack
vid_addr  in  ADDR_W  video read address, stable while vid_req
vid_ack  out  1  one-cycle pulse, vid_data valid
vid_data  out  8  video read data, held until next vid_ack
cpu_req  in  1  CPU read request, held until cpu_ack
cpu_addr  in  ADDR_W  CPU read address
cpu_ack  out  1  one-cycle pulse, cpu_data valid
cpu_data  out  8  CPU read data, held until next cpu_ack
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_din  out  8  RAM write data (registered)
mem_dout  in  8  RAM read data, valid one edge after mem_addr sampled
game_reset  out  1  active-high reset to zaxxon core
dl_overflow  out  1  sticky: download byte dropped
dl_checksum  out  16  download checksum (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at an edge): all outputs 0 except game_reset=1. FSM goes to S_IDLE. Write buffer is emptied. Starve counter = 0. Hold counter = HOLD_CYCLES.
- FSM states:
  - S_IDLE: a granted read registers mem_addr and moves to S_WAIT.
  - S_WAIT: RAM samples the address; moves to S_CAP.
  - S_CAP: latches mem_dout into the winner's data register and pulses its ack. In the same edge it re-arbitrates: grant -> S_WAIT, otherwise -> S_IDLE.
- Read latency: req sampled at edge E0 -> ack high after E2. Back-to-back throughput is one read per 2 cycles.
- Requester handshake: the requester must drop req, or present a new address, in the cycle ack is high. A req still high at the S_CAP edge counts as a new request.
- Arbitration (S_IDLE and S_CAP edges):
  - No read is granted while dl_download=1 or the write buffer is non-empty.
  - Otherwise video wins over CPU, unless starve counter = CPU_STARVE, in which case CPU wins.
  - Starve counter increments on each video grant while cpu_req=1. It clears on CPU grant or when cpu_req=0. It saturates at CPU_STARVE.
- Writes:
  - dl_wr with FSM in S_IDLE or S_CAP and no read granted: mem_addr/mem_din/mem_we=1 registered next edge for exactly one cycle. The FSM stays in or returns to S_IDLE.
  - dl_wr while a read is in flight (S_WAIT, or S_CAP granting): byte goes into a 1-entry buffer and is written at the first S_IDLE/S_CAP edge. Buffered writes have priority over reads.
  - dl_wr while the buffer is full: byte is dropped and dl_overflow is set to 1. dl_overflow clears only on reset.
  - dl_wr is ignored when dl_download=0.
- Download start mid-read: the in-flight read completes and is acked normally. Pending requests wait, un-acked, until dl_download falls.
- mem_we=0 whenever not writing. mem_addr holds its last value when idle.
- game_reset:
  - 1 while dl_download=1; the hold counter reloads to HOLD_CYCLES.
  - After dl_download falls, counts down once per cycle. game_reset drops the edge the counter reaches 0, i.e. exactly HOLD_CYCLES cycles after the fall.
  - A new download during the countdown reloads the counter.
- Reset mid-operation: in-flight read is abandoned with no ack, and the buffered write is lost.

Optional Feature:
ROM_CHECKSUM_EN
- Defined: dl_checksum = 16-bit wrapping sum of every byte actually written to RAM. Cleared on the rising edge of dl_download and on reset. Stable after download ends.
- Undefined: dl_checksum is constant 0 and no adder is instantiated.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> game_reset=1, acks=0, mem_we=0, dl_overflow=0. Release, dl_download=0 -> game_reset falls after 16 cycles.
- Single read: RAM[0x01234]=0xA5, vid_req with addr 0x01234 at E0 -> vid_ack high after E2 with vid_data=0xA5; cpu_ack stays 0.
- Starvation: vid_req and cpu_req held continuously with CPU_STARVE=4 -> grant order V,V,V,V,C,V,V,V,V,C, each ack 2 cycles apart.
- Download: dl_download=1, write 0x11,0x22,0x33 to 0x0,0x1,0x2 with 4-cycle spacing -> three 1-cycle mem_we pulses, no acks while reads are pending. With ROM_CHECKSUM_EN, dl_checksum=0x0066.
- Write collision: start vid read, pulse dl_wr at S_WAIT and again at next cycle -> first byte buffered and written after the ack, second byte dropped, dl_overflow=1.
- Reset mid-read: reset_n=0 in S_WAIT -> no ack, state S_IDLE, game_reset=1.
